lc4_dmem_unit: RTL and testbench

//  Data-memory access stage directly downstream of the LC4 data controller: takes its

---
 rtl/lc4_dmem_unit.sv | 140 ++++++++++++++
 tb/tb_lc4_dmem_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lc4_dmem_unit.sv
// lc4_dmem_unit
//   Data-memory access stage that sits after the LC4 data controller. It takes the
//   load/store request, runs one req/ack transaction to a variable-latency memory,
//   and holds the core in a stall until that access retires. User-mode accesses to
//   OS space are refused without touching memory. A bounded wait turns a missing
//   ack into a timeout completion.
//
//   Ports
//     clk, rst                  clock, asynchronous active-high reset
//     i_req_valid, i_is_store   request present / store(1) or load(0)
//     i_privilege               1 = OS mode, 0 = user mode
//     i_addr, i_store_data      effective address and store data
//     o_stall                   freeze PC / regfile write this cycle
//     o_done                    one-cycle retire pulse
//     o_rdata, o_fault,         load data and completion status; meaningful only
//     o_timeout                   while o_done = 1, zero otherwise
//     o_mem_req, o_mem_we,      registered memory request bus
//     o_mem_addr, o_mem_wdata
//     i_mem_ack, i_mem_rdata    memory completion and read data
module lc4_dmem_unit #(
  parameter int          TIMEOUT = 16,
  parameter logic [15:0] OS_BASE = 16'hA000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  input  logic        i_is_store,
  input  logic        i_privilege,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_store_data,
  output logic        o_stall,
  output logic        o_done,
  output logic [15:0] o_rdata,
  output logic        o_fault,
  output logic        o_timeout,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  count_reg;
  logic [15:0] rdata_reg;
  logic        fault_reg;
  logic        timeout_reg;
  logic        prot_fault;
  logic        last_count;

  assign prot_fault = ~i_privilege & (i_addr >= OS_BASE);
  // The BUSY cycle holding this count is the last one we wait for an ack.
  assign last_count = (count_reg == 8'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (i_req_valid) state_next = prot_fault ? DONE : BUSY;
      BUSY: if (i_mem_ack || last_count) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_done    = (state_reg == DONE);
    // Reset forces the stall low immediately, even while the core still holds
    // its request, so the pipeline is released in the reset cycle itself.
    o_stall   = i_req_valid & ~o_done & ~rst;
    o_rdata   = o_done ? rdata_reg : 16'h0000;
    o_fault   = o_done & fault_reg;
    o_timeout = o_done & timeout_reg;
  end

  // Memory request bus, wait counter and completion status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= 16'h0000;
      o_mem_wdata <= 16'h0000;
      count_reg   <= 8'd0;
      rdata_reg   <= 16'h0000;
      fault_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_req_valid) begin
            rdata_reg   <= 16'h0000;
            timeout_reg <= 1'b0;
            if (prot_fault) begin
              fault_reg <= 1'b1;
            end else begin
              fault_reg   <= 1'b0;
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_is_store;
              o_mem_addr  <= i_addr;
              o_mem_wdata <= i_store_data;
              count_reg   <= 8'd0;
            end
          end
        end
        BUSY: begin
          // An ack on the final count takes priority over the timeout.
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            rdata_reg <= o_mem_we ? 16'h0000 : i_mem_rdata;
          end else if (last_count) begin
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            timeout_reg <= 1'b1;
            rdata_reg   <= 16'h0000;
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end
        DONE: begin
          rdata_reg   <= 16'h0000;
          fault_reg   <= 1'b0;
          timeout_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc4_dmem_unit.sv
// tb_lc4_dmem_unit
//   Drives lc4_dmem_unit with directed and random load/store transactions and a
//   simple memory responder, comparing every cycle against a transaction-level
//   model: protection check, ack cycle versus the wait bound, and returned data.
module tb_lc4_dmem_unit;

  localparam int          TO   = 16;
  localparam logic [15:0] BASE = 16'hA000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_is_store, i_privilege;
  logic [15:0] i_addr, i_store_data;
  logic        o_stall, o_done, o_fault, o_timeout;
  logic [15:0] o_rdata;
  logic        o_mem_req, o_mem_we;
  logic [15:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ack;
  logic [15:0] i_mem_rdata;

  int checks = 0;
  int errors = 0;

  lc4_dmem_unit #(.TIMEOUT(TO), .OS_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_is_store(i_is_store), .i_privilege(i_privilege),
    .i_addr(i_addr), .i_store_data(i_store_data),
    .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata),
    .o_fault(o_fault), .o_timeout(o_timeout),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One access. ack_cyc is the cycle (request cycle = 0) in which memory acks;
  // 255 means never. Returns at the falling edge of the completion cycle.
  task automatic txn(input logic st, input logic priv, input logic [15:0] addr,
                     input logic [15:0] wdata, input int ack_cyc, input logic [15:0] ack_data);
    logic        exp_fault, exp_to;
    logic [15:0] exp_rd;
    int          exp_done;
    bit          ok;
    // Reference: the outcome follows from the rules, not from the machine.
    exp_fault = !priv && (addr >= BASE);
    exp_to    = 1'b0;
    exp_rd    = 16'h0000;
    if (exp_fault) begin
      exp_done = 1;
    end else if (ack_cyc <= TO) begin
      exp_done = ack_cyc + 1;
      exp_rd   = st ? 16'h0000 : ack_data;
    end else begin
      exp_done = TO + 1;
      exp_to   = 1'b1;
    end

    @(posedge clk); #1;
    i_req_valid = 1'b1; i_is_store = st; i_privilege = priv;
    i_addr = addr; i_store_data = wdata;
    i_mem_ack = 1'b0; i_mem_rdata = 16'($urandom);
    ok = 1'b0;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      @(negedge clk);
      chk("stall", o_stall, cyc != exp_done);
      chk("done", o_done, cyc == exp_done);
      chk("mem_req", o_mem_req, !exp_fault && cyc >= 1 && cyc < exp_done);
      if (o_mem_req) begin
        chk("mem_we", o_mem_we, st);
        chk("mem_addr", o_mem_addr, addr);
        if (st) chk("mem_wdata", o_mem_wdata, wdata);
      end
      if (cyc == exp_done) begin
        chk("rdata", o_rdata, exp_rd);
        chk("fault", o_fault, exp_fault);
        chk("timeout", o_timeout, exp_to);
        $display("txn st=%0d priv=%0d addr=%h ack@%0d -> done@%0d rdata=%h fault=%0d to=%0d",
                 st, priv, addr, ack_cyc, cyc, o_rdata, o_fault, o_timeout);
        ok = 1'b1;
        break;
      end else begin
        chk("rdata_idle", o_rdata, 16'h0000);
      end
      @(posedge clk); #1;
      i_mem_ack   = (cyc + 1 == ack_cyc);
      i_mem_rdata = (cyc + 1 == ack_cyc) ? ack_data : 16'($urandom);
    end
    if (!ok) chk("watchdog", 1, 0);
  endtask

  // Quiet cycles with no request; optionally spurious acks that must be ignored.
  task automatic idle(input int n, input bit spurious);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      i_mem_ack   = spurious ? 1'($urandom) : 1'b0;
      i_mem_rdata = 16'($urandom);
      @(negedge clk);
      chk("idle_stall", o_stall, 0);
      chk("idle_done", o_done, 0);
      chk("idle_mem_req", o_mem_req, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_req_valid = 0; i_is_store = 0; i_privilege = 0;
    i_addr = 0; i_store_data = 0; i_mem_ack = 0; i_mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_stall", o_stall, 0);
    chk("rst_done", o_done, 0);
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_rdata", o_rdata, 0);
    rst = 1'b0;

    // Directed cases
    txn(0, 0, 16'h4000, 16'h0000, 3, 16'h1234);
    idle(1, 0);
    txn(1, 0, 16'h5000, 16'hBEEF, 1, 16'h5555);
    idle(1, 0);
    txn(0, 0, 16'hC000, 16'h0000, 2, 16'h7777);
    txn(0, 1, 16'hC000, 16'h0000, 2, 16'h7777);
    txn(0, 0, 16'h6000, 16'h0000, 255, 16'h0000);
    idle(4, 1);                                    // late acks ignored
    txn(0, 0, 16'h4000, 16'h0000, 1, 16'hAAAA);    // back-to-back
    txn(0, 0, 16'h4001, 16'h0000, 1, 16'hBBBB);
    txn(0, 0, 16'h1000, 16'h0000, TO, 16'hCAFE);   // ack on final count wins
    txn(0, 0, 16'h1001, 16'h0000, TO + 1, 16'hCAFE);
    txn(1, 0, 16'h9FFF, 16'h1111, 2, 16'h2222);
    txn(1, 0, 16'hA000, 16'h1111, 2, 16'h2222);
    txn(0, 0, 16'hFFFF, 16'h0000, 2, 16'h2222);
    idle(1, 0);

    // Reset in the middle of BUSY
    @(posedge clk); #1;
    i_req_valid = 1; i_is_store = 0; i_privilege = 0; i_addr = 16'h7000;
    i_mem_ack = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("pre_rst_req", o_mem_req, 1);
    rst = 1'b1;
    #1;
    chk("arst_mem_req", o_mem_req, 0);
    chk("arst_stall", o_stall, 0);
    chk("arst_done", o_done, 0);
    @(negedge clk);
    rst = 1'b0; i_req_valid = 0;
    @(negedge clk);
    chk("post_rst_req", o_mem_req, 0);
    chk("post_rst_done", o_done, 0);
    txn(0, 0, 16'h7000, 16'h0000, 2, 16'h3C3C);

    // Random transactions
    for (int t = 0; t < 40; t++) begin
      txn(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
          $urandom_range(1, TO + 4), 16'($urandom));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2), 1'($urandom));
    end
    idle(1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
